// File: rtl/if_id_queue_pkg.sv
// Shared constants and types for the IF->ID fetch queue.
// Stall vector bit positions and the default-width fetch bundle.
package if_id_queue_pkg;

    localparam int STALL_INST = 0;
    localparam int STALL_ID   = 1;
    localparam int STALL_EXE  = 2;
    localparam int STALL_DATA = 3;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;
    localparam int DEF_EXC_W  = 32;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_INST_W-1:0] inst;
        logic [DEF_EXC_W-1:0]  exc;
    } fetch_bundle_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side signals of the IF->ID queue.
// The queue itself takes the slave view; the fetch/decode environment takes the master view.
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 32,
    parameter int DEPTH  = 4
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] postif_pc_i;
    logic [INST_W-1:0] postif_inst_i;
    logic [EXC_W-1:0]  postif_exception_type_i;
    logic              postif_valid_i;
    logic              postif_ready_o;
    logic              kill_i;
    logic              flush_i;
    logic [3:0]        stall_i;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic [EXC_W-1:0]  id_exception_type_o;
    logic              id_valid_o;
    logic [CNT_W-1:0]  count_o;
    logic              overflow_o;

    modport slave (
        input  postif_pc_i, postif_inst_i, postif_exception_type_i, postif_valid_i,
        input  kill_i, flush_i, stall_i,
        output postif_ready_o, id_pc_o, id_inst_o, id_exception_type_o, id_valid_o,
        output count_o, overflow_o
    );

    modport master (
        output postif_pc_i, postif_inst_i, postif_exception_type_i, postif_valid_i,
        output kill_i, flush_i, stall_i,
        input  postif_ready_o, id_pc_o, id_inst_o, id_exception_type_o, id_valid_o,
        input  count_o, overflow_o
    );

endinterface

// File: rtl/if_id_fifo_mem.sv
// Storage array for queued fetch bundles: one write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the owner's count.
module if_id_fifo_mem #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock_i,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry circular FIFO between post-fetch and decode with registered ID outputs.
// An empty queue bypasses the incoming beat straight to ID for one-cycle latency.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 32,
    parameter int DEPTH  = 4
) (
    input  logic          clock_i,
    input  logic          reset_i,
    if_id_queue_if.slave  q
);

    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int BUNDLE_W = ADDR_W + INST_W + EXC_W;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic [EXC_W-1:0]  exc;
    } bundle_t;

    bundle_t           in_bundle;
    bundle_t           head_bundle;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [EXC_W-1:0]  id_exc;
    logic              id_valid;

    logic full;
    logic empty;
    logic push_req;
    logic advance;
    logic go;
    logic pop;
    logic bypass;
    logic write_en;

    assign in_bundle = '{pc: q.postif_pc_i, inst: q.postif_inst_i, exc: q.postif_exception_type_i};

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_req = q.postif_valid_i & ~q.kill_i & ~q.flush_i;
    assign advance  = ~(q.stall_i[STALL_ID] | q.stall_i[STALL_EXE] | q.stall_i[STALL_DATA]);
    assign go       = advance & ~q.stall_i[STALL_INST];
    assign pop      = go & ~empty;
    assign bypass   = go & empty & push_req;
    // A full queue drops the beat in every mode; fetch is expected to honour ready.
    assign write_en = push_req & ~full & ~bypass;

    if_id_fifo_mem #(
        .WIDTH (BUNDLE_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock_i (clock_i),
        .we      (write_en),
        .waddr   (tail),
        .wdata   (in_bundle),
        .raddr   (head),
        .rdata   (head_bundle)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
            id_exc   <= '0;
            id_valid <= 1'b0;
        end else if (q.flush_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
            id_exc   <= '0;
            id_valid <= 1'b0;
        end else begin
            if (write_en) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (write_en && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!write_en && pop) begin
                count <= count - CNT_W'(1);
            end
            if (push_req && full) begin
                overflow <= 1'b1;
            end
            // Downstream hold leaves the ID register untouched; pc survives an inst-stall bubble.
            if (advance) begin
                if (q.stall_i[STALL_INST]) begin
                    id_inst  <= '0;
                    id_exc   <= '0;
                    id_valid <= 1'b0;
                end else if (pop) begin
                    id_pc    <= head_bundle.pc;
                    id_inst  <= head_bundle.inst;
                    id_exc   <= head_bundle.exc;
                    id_valid <= 1'b1;
                end else if (bypass) begin
                    id_pc    <= in_bundle.pc;
                    id_inst  <= in_bundle.inst;
                    id_exc   <= in_bundle.exc;
                    id_valid <= 1'b1;
                end else begin
                    id_pc    <= '0;
                    id_inst  <= '0;
                    id_exc   <= '0;
                    id_valid <= 1'b0;
                end
            end
        end
    end

    assign q.postif_ready_o      = ~full;
    assign q.id_pc_o             = id_pc;
    assign q.id_inst_o           = id_inst;
    assign q.id_exception_type_o = id_exc;
    assign q.id_valid_o          = id_valid;
    assign q.count_o             = count;
    assign q.overflow_o          = overflow;

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF→ID pipeline register.
- Sits between post-fetch (postif) and decode (ID), replacing the one-deep skid buffer with a DEPTH-entry circular FIFO of {pc, inst, exception_type}.
- Keeps fetch streaming while decode/execute/data stalls persist, and gives backpressure via postif_ready_o.
- Registered ID-side outputs; empty-queue bypass gives one-cycle fetch-to-ID latency.

Parameters:
- ADDR_W, 32, width of pc.
- INST_W, 32, width of instruction word.
- EXC_W, 32, width of exception-type vector.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden).

Ports:
- clock_i  in  1  sole clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- postif_pc_i  in  ADDR_W  fetched pc.
- postif_inst_i  in  INST_W  fetched instruction.
- postif_exception_type_i  in  EXC_W  fetch-stage exception bits.
- postif_valid_i  in  1  fetch beat valid this cycle.
- postif_ready_o  out  1  queue can accept a beat: count_o < DEPTH.
- kill_i  in  1  branch taken: drop the incoming beat this cycle.
- flush_i  in  1  exception: discard all queued and presented state.
- stall_i  in  4  [0] inst stall, [1] id stall, [2] exe stall, [3] data stall.
- id_pc_o  out  ADDR_W  pc to decode.
- id_inst_o  out  INST_W  instruction to decode; 0 = bubble (nop).
- id_exception_type_o  out  EXC_W  exception bits to decode.
- id_valid_o  out  1  id_* holds a real instruction.
- count_o  out  CNT_W  current occupancy.
- overflow_o  out  1  sticky: a valid beat arrived while full; cleared by reset or flush.

Behaviour:
- Reset (reset_i=0, async): all id_* outputs 0, id_valid_o=0, head/tail pointers 0, count 0, overflow_o 0. Queue storage need not be cleared.
- Derived signals:
  - push_req = postif_valid_i & ~kill_i & ~flush_i.
  - advance = ~(stall_i[1] | stall_i[2] | stall_i[3]).
- Priority per clock edge: flush_i > downstream hold > inst stall > normal.
- flush_i=1: same result as reset, except overflow_o also clears. Incoming beat is dropped. postif_ready_o is 1 on the next cycle.
- advance=0 (downstream hold):
  - id_* outputs and id_valid_o hold their values.
  - If push_req and count<DEPTH: write at tail, tail+1, count+1.
  - If push_req and count==DEPTH: beat dropped, overflow_o←1.
- advance=1, stall_i[0]=1 (bubble insert):
  - id_inst_o←0, id_exception_type_o←0, id_valid_o←0, id_pc_o holds.
  - No pop. Push rules as in hold.
- advance=1, stall_i[0]=0 (normal):
  - count>0: present head entry on id_*, id_valid_o←1, head+1. Simultaneous push writes tail, so count is unchanged (push+pop) or −1 (pop only).
  - count==0 and push_req: bypass. The incoming beat goes straight to id_*, id_valid_o←1, count stays 0.
  - count==0 and no push_req: bubble (id_pc_o, id_inst_o, id_exception_type_o, id_valid_o all ←0).
- Ordering: strict FIFO. Queued entries always reach ID before any newer beat.
- kill_i affects only the incoming beat. Already-queued entries (including the delay-slot instruction) are delivered.
- Pointer wrap: head/tail are log2(DEPTH) bits and wrap naturally. Full/empty come from count, not pointer compare.
- postif_ready_o is combinational from registered count only; it has no path from stall_i.
- Reset asserted mid-operation: immediate clear, no partial state.

Decomposition:
- Shared package holds:
  - the stall_i bit-index constants (STALL_INST=0, STALL_ID=1, STALL_EXE=2, STALL_DATA=3);
  - a packed fetch-bundle typedef {pc, inst, exc} sized by the parameters.
- One natural sub-module: if_id_fifo_mem, a DEPTH×bundle register array with one write port and one async read port at head. Pointers, count and the output register stay in if_id_queue.

Test Plan:
- Reset then stream pc 0xBFC00000,+4,+8 with stall_i=0 → id_pc_o follows one cycle later via bypass, count_o stays 0, id_valid_o=1.
- stall_i=4'b0100 for 5 cycles while fetching 0x100..0x10C → id_* frozen, count_o reaches 4, postif_ready_o=0, 5th beat sets overflow_o=1. After release, pops 0x100,0x104,0x108,0x10C in order.
- Queue holds 2 entries and kill_i=1 with valid beat 0x200 → 0x200 never appears on id_pc_o, both queued entries are delivered.
- flush_i=1 with count=3 and valid input → next cycle id_inst_o=0, id_valid_o=0, count_o=0, overflow_o=0, postif_ready_o=1.
- stall_i=4'b0001 with count=1 → id_inst_o=0, id_pc_o unchanged, count_o still 1. Next normal cycle presents the queued entry.
- reset_i deasserted then asserted asynchronously between edges while full → all outputs 0 immediately, without waiting for a clock edge.
